// File: rtl/prio_req_arbiter.sv
// Registered priority arbiter: sticky pending register, one grant at a time under valid/ready.
// Define ROUND_ROBIN_EN for rotating priority (ptr register); default is fixed highest-index-wins.
//
// state | meaning
// IDLE  | no grant outstanding; grant is issued next edge if pending is non-zero
// GRANT | grant_idx/grant_onehot presented and held until grant_ready
module prio_req_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N),
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          grant_ready,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic [N-1:0]  grant_onehot,
  output logic [CW-1:0] pending_cnt,
  output logic          pending_any
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_next;
  logic [N-1:0]  pending, pending_next, clr, rem, onehot_next;
  logic [IW-1:0] idx_next, idle_start, accept_start;
  logic          accept;

  // Descending search from start with wrap-around; fixed priority is the start = N-1 case.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] vec, input logic [IW-1:0] start);
    logic [IW-1:0] win;
    logic [IW-1:0] jj;
    logic          found;
    int            j;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) - i;
      if (j < 0) j = j + N;
      jj = IW'(j);
      if (!found && vec[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
    return win;
  endfunction

  function automatic logic [N-1:0] onehot_of(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] vec);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(vec[i]);
    return c;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] ptr, ptr_next;

  assign idle_start   = ptr;
  assign accept_start = (grant_idx == '0) ? IW'(N-1) : grant_idx - IW'(1);

  always_comb begin
    ptr_next = ptr;
    if (accept) ptr_next = accept_start;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= IW'(N-1);
    else        ptr <= ptr_next;
  end
`else
  assign idle_start   = IW'(N-1);
  assign accept_start = IW'(N-1);
`endif

  assign grant_valid = (state == GRANT);

  always_comb begin
    state_next   = state;
    idx_next     = grant_idx;
    onehot_next  = grant_onehot;
    accept       = (state == GRANT) && grant_ready;
    rem          = pending & ~grant_onehot;
    clr          = accept ? grant_onehot : '0;
    // Same-cycle req sets after the clear, so a re-request survives its own accept.
    pending_next = (pending & ~clr) | req;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next  = GRANT;
          idx_next    = pick(pending, idle_start);
          onehot_next = onehot_of(idx_next);
        end
      end
      GRANT: begin
        if (grant_ready) begin
          if (|rem) begin
            idx_next    = pick(rem, accept_start);
            onehot_next = onehot_of(idx_next);
          end else begin
            state_next  = IDLE;
            onehot_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= '0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      pending_cnt  <= '0;
      pending_any  <= 1'b0;
    end else begin
      state        <= state_next;
      pending      <= pending_next;
      grant_idx    <= idx_next;
      grant_onehot <= onehot_next;
      pending_cnt  <= popcount(pending_next);
      pending_any  <= |pending_next;
    end
  end

endmodule
